// File: rtl/cache_def.sv
// Shared cache geometry and line-transfer record types used by the L1/victim-cache glue.
package cache_def;

    localparam int unsigned LineW = 128;
    localparam int unsigned AddrW = 32;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [AddrW-1:0] addr;
        logic [LineW-1:0] data;
    } evict_t;

    typedef struct packed {
        logic             dirty;
        logic [LineW-1:0] data;
    } vc_res_t;

endpackage

// File: rtl/adder_32bit.sv
// Shared 32-bit combinational adder; the carry-out is dropped so sums wrap modulo 2^32.
module adder_32bit (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/l1_vc_swap_controller.sv
// Services an L1 miss from the victim cache when possible, else from memory, and swaps
// the displaced L1 line into the victim cache in the same cycle as the refill.
module l1_vc_swap_controller
    import cache_def::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             l1_miss_valid_i,
    input  logic [AddrW-1:0] l1_miss_addr_i,
    input  logic             l1_victim_valid_i,
    input  logic             l1_victim_dirty_i,
    input  logic [AddrW-1:0] l1_victim_addr_i,
    input  logic [LineW-1:0] l1_victim_data_i,
    output logic             vc_req_valid_o,
    output logic [AddrW-1:0] vc_req_addr_o,
    input  logic             vc_res_valid_i,
    input  logic             vc_res_dirty_i,
    input  logic [LineW-1:0] vc_res_data_i,
    input  logic             vc_miss_i,
    output logic             evict_valid_o,
    output logic             evict_dirty_o,
    output logic [AddrW-1:0] evict_addr_o,
    output logic [LineW-1:0] evict_data_o,
    output logic             mem_req_valid_o,
    output logic [AddrW-1:0] mem_req_addr_o,
    input  logic             mem_ready_i,
    input  logic [LineW-1:0] mem_data_i,
    output logic             fill_valid_o,
    output logic             fill_dirty_o,
    output logic [LineW-1:0] fill_data_o,
    output logic             busy_o,
    output logic [31:0]      no_swap_o,
    output logic [31:0]      no_memfill_o
);

    typedef enum logic [2:0] {StIdle, StProbe, StWaitRes, StMemReq, StRespond} state_e;

    state_e           state_q, state_d;
    logic [AddrW-1:0] miss_addr_q, miss_addr_d;
    evict_t           victim_q, victim_d;
    vc_res_t          fill_src_q, fill_src_d;
    logic [31:0]      no_swap_q, no_swap_d, no_swap_inc;
    logic [31:0]      no_memfill_q, no_memfill_d, no_memfill_inc;
    logic             swap_hit, mem_done;

    adder_32bit u_swap_adder (
        .a_i   (no_swap_q),
        .b_i   (32'd1),
        .sum_o (no_swap_inc)
    );

    adder_32bit u_memfill_adder (
        .a_i   (no_memfill_q),
        .b_i   (32'd1),
        .sum_o (no_memfill_inc)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            miss_addr_q  <= '0;
            victim_q     <= '0;
            fill_src_q   <= '0;
            no_swap_q    <= '0;
            no_memfill_q <= '0;
        end else begin
            state_q      <= state_d;
            miss_addr_q  <= miss_addr_d;
            victim_q     <= victim_d;
            fill_src_q   <= fill_src_d;
            no_swap_q    <= no_swap_d;
            no_memfill_q <= no_memfill_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        miss_addr_d     = miss_addr_q;
        victim_d        = victim_q;
        fill_src_d      = fill_src_q;
        swap_hit        = 1'b0;
        mem_done        = 1'b0;
        busy_o          = 1'b1;
        vc_req_valid_o  = 1'b0;
        vc_req_addr_o   = '0;
        mem_req_valid_o = 1'b0;
        mem_req_addr_o  = '0;
        fill_valid_o    = 1'b0;
        fill_dirty_o    = 1'b0;
        fill_data_o     = '0;
        evict_valid_o   = 1'b0;
        evict_dirty_o   = 1'b0;
        evict_addr_o    = '0;
        evict_data_o    = '0;

        unique case (state_q)
            StIdle: begin
                busy_o = 1'b0;
                if (l1_miss_valid_i) begin
                    miss_addr_d = l1_miss_addr_i;
                    victim_d    = '{valid: l1_victim_valid_i, dirty: l1_victim_dirty_i,
                                    addr: l1_victim_addr_i, data: l1_victim_data_i};
                    state_d     = StProbe;
                end
            end
            StProbe: begin
                vc_req_valid_o = 1'b1;
                vc_req_addr_o  = miss_addr_q;
                state_d        = StWaitRes;
            end
            StWaitRes: begin
                vc_req_addr_o = miss_addr_q;
                // A result flagged as both valid and miss is treated as a miss.
                if (vc_res_valid_i && !vc_miss_i) begin
                    swap_hit   = 1'b1;
                    fill_src_d = '{dirty: vc_res_dirty_i, data: vc_res_data_i};
                    state_d    = StRespond;
                end else begin
                    state_d = StMemReq;
                end
            end
            StMemReq: begin
                mem_req_valid_o = 1'b1;
                mem_req_addr_o  = miss_addr_q;
                if (mem_ready_i) begin
                    mem_done   = 1'b1;
                    fill_src_d = '{dirty: 1'b0, data: mem_data_i};
                    state_d    = StRespond;
                end
            end
            StRespond: begin
                fill_valid_o  = 1'b1;
                fill_dirty_o  = fill_src_q.dirty;
                fill_data_o   = fill_src_q.data;
                // Victim fields are only presented alongside a valid evict.
                evict_valid_o = victim_q.valid;
                if (victim_q.valid) begin
                    evict_dirty_o = victim_q.dirty;
                    evict_addr_o  = victim_q.addr;
                    evict_data_o  = victim_q.data;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        no_swap_d    = swap_hit ? no_swap_inc : no_swap_q;
        no_memfill_d = mem_done ? no_memfill_inc : no_memfill_q;
    end

    assign no_swap_o    = no_swap_q;
    assign no_memfill_o = no_memfill_q;

endmodule

// File: tb/tb_l1_vc_swap_controller.sv
// Randomized bench for l1_vc_swap_controller: each miss is checked cycle by cycle against a
// transaction-level timeline derived from the expected hit/memory latencies.
module tb_l1_vc_swap_controller;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         l1_miss_valid_i;
    logic [31:0]  l1_miss_addr_i;
    logic         l1_victim_valid_i;
    logic         l1_victim_dirty_i;
    logic [31:0]  l1_victim_addr_i;
    logic [127:0] l1_victim_data_i;
    logic         vc_req_valid_o;
    logic [31:0]  vc_req_addr_o;
    logic         vc_res_valid_i;
    logic         vc_res_dirty_i;
    logic [127:0] vc_res_data_i;
    logic         vc_miss_i;
    logic         evict_valid_o;
    logic         evict_dirty_o;
    logic [31:0]  evict_addr_o;
    logic [127:0] evict_data_o;
    logic         mem_req_valid_o;
    logic [31:0]  mem_req_addr_o;
    logic         mem_ready_i;
    logic [127:0] mem_data_i;
    logic         fill_valid_o;
    logic         fill_dirty_o;
    logic [127:0] fill_data_o;
    logic         busy_o;
    logic [31:0]  no_swap_o;
    logic [31:0]  no_memfill_o;

    int unsigned  n_checks = 0;
    int unsigned  n_pass = 0;
    logic [31:0]  exp_swap = '0;
    logic [31:0]  exp_memfill = '0;

    always #5 clk_i = ~clk_i;

    l1_vc_swap_controller dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .l1_miss_valid_i   (l1_miss_valid_i),
        .l1_miss_addr_i    (l1_miss_addr_i),
        .l1_victim_valid_i (l1_victim_valid_i),
        .l1_victim_dirty_i (l1_victim_dirty_i),
        .l1_victim_addr_i  (l1_victim_addr_i),
        .l1_victim_data_i  (l1_victim_data_i),
        .vc_req_valid_o    (vc_req_valid_o),
        .vc_req_addr_o     (vc_req_addr_o),
        .vc_res_valid_i    (vc_res_valid_i),
        .vc_res_dirty_i    (vc_res_dirty_i),
        .vc_res_data_i     (vc_res_data_i),
        .vc_miss_i         (vc_miss_i),
        .evict_valid_o     (evict_valid_o),
        .evict_dirty_o     (evict_dirty_o),
        .evict_addr_o      (evict_addr_o),
        .evict_data_o      (evict_data_o),
        .mem_req_valid_o   (mem_req_valid_o),
        .mem_req_addr_o    (mem_req_addr_o),
        .mem_ready_i       (mem_ready_i),
        .mem_data_i        (mem_data_i),
        .fill_valid_o      (fill_valid_o),
        .fill_dirty_o      (fill_dirty_o),
        .fill_data_o       (fill_data_o),
        .busy_o            (busy_o),
        .no_swap_o         (no_swap_o),
        .no_memfill_o      (no_memfill_o)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, obs, exp);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".busy"}, 128'(busy_o), 128'd0);
        check({tag, ".vc_req"}, 128'({vc_req_valid_o, vc_req_addr_o}), 128'd0);
        check({tag, ".mem_req"}, 128'({mem_req_valid_o, mem_req_addr_o}), 128'd0);
        check({tag, ".fill"}, 128'(fill_valid_o), 128'd0);
        check({tag, ".fill_data"}, fill_data_o, 128'd0);
        check({tag, ".evict"}, 128'({evict_valid_o, evict_dirty_o, evict_addr_o}), 128'd0);
        check({tag, ".no_swap"}, 128'(no_swap_o), 128'(exp_swap));
        check({tag, ".no_memfill"}, 128'(no_memfill_o), 128'(exp_memfill));
    endtask

    // One complete miss, starting from IDLE just after a clock edge.
    task automatic txn(input logic [31:0] addr, input logic vv, input logic vd,
                       input logic [31:0] vaddr, input logic [127:0] vdata, input logic hit,
                       input logic rdirty, input logic [127:0] rdata, input int n_wait,
                       input logic [127:0] mdata, input logic extra_miss);
        logic         rv, rm;
        logic         exp_dirty;
        logic [127:0] exp_data;
        rv = hit ? 1'b1 : 1'($urandom_range(1));
        rm = hit ? 1'b0 : (rv ? 1'b1 : 1'($urandom_range(1)));
        l1_miss_valid_i   = 1'b1;
        l1_miss_addr_i    = addr;
        l1_victim_valid_i = vv;
        l1_victim_dirty_i = vd;
        l1_victim_addr_i  = vaddr;
        l1_victim_data_i  = vdata;
        step();
        // PROBE: scramble the L1 side so only captured values can match.
        l1_miss_valid_i   = 1'b0;
        l1_miss_addr_i    = $urandom();
        l1_victim_valid_i = 1'($urandom_range(1));
        l1_victim_dirty_i = 1'($urandom_range(1));
        l1_victim_addr_i  = $urandom();
        l1_victim_data_i  = rand128();
        check("probe.busy", 128'(busy_o), 128'd1);
        check("probe.vc_req", 128'({vc_req_valid_o, vc_req_addr_o}), 128'({1'b1, addr}));
        check("probe.fill", 128'({fill_valid_o, evict_valid_o, mem_req_valid_o}), 128'd0);
        mem_ready_i = 1'($urandom_range(1));
        mem_data_i  = rand128();
        step();
        check("wait.vc_req", 128'({vc_req_valid_o, vc_req_addr_o}), 128'({1'b0, addr}));
        check("wait.other", 128'({fill_valid_o, evict_valid_o, mem_req_valid_o, busy_o}),
              128'd1);
        vc_res_valid_i = rv;
        vc_miss_i      = rm;
        vc_res_dirty_i = hit ? rdirty : 1'($urandom_range(1));
        vc_res_data_i  = hit ? rdata : rand128();
        mem_ready_i    = 1'b0;
        step();
        vc_res_valid_i = 1'($urandom_range(1));
        vc_miss_i      = 1'b0;
        vc_res_dirty_i = 1'($urandom_range(1));
        vc_res_data_i  = rand128();
        if (hit) begin
            exp_swap++;
            exp_dirty = rdirty;
            exp_data  = rdata;
        end else begin
            for (int i = 0; i < n_wait; i++) begin
                check("mem.req", 128'({mem_req_valid_o, mem_req_addr_o}), 128'({1'b1, addr}));
                check("mem.other", 128'({vc_req_valid_o, vc_req_addr_o, fill_valid_o,
                      evict_valid_o, busy_o}), 128'd1);
                if (extra_miss && i == 0) begin
                    l1_miss_valid_i = 1'b1;
                    l1_miss_addr_i  = $urandom();
                end
                mem_ready_i = (i == n_wait - 1);
                mem_data_i  = (i == n_wait - 1) ? mdata : rand128();
                step();
                l1_miss_valid_i = 1'b0;
            end
            mem_ready_i = 1'b0;
            mem_data_i  = rand128();
            exp_memfill++;
            exp_dirty   = 1'b0;
            exp_data    = mdata;
        end
        // RESPOND: miss-to-fill latency is 3 cycles, plus the memory wait when the VC missed.
        check("resp.fill", 128'({fill_valid_o, fill_dirty_o}), 128'({1'b1, exp_dirty}));
        check("resp.fill_data", fill_data_o, exp_data);
        check("resp.busy", 128'({busy_o, mem_req_valid_o, vc_req_valid_o}), 128'b100);
        check("resp.evict_valid", 128'(evict_valid_o), 128'(vv));
        if (vv) begin
            check("resp.evict", 128'({evict_dirty_o, evict_addr_o}), 128'({vd, vaddr}));
            check("resp.evict_data", evict_data_o, vdata);
        end
        check("resp.no_swap", 128'(no_swap_o), 128'(exp_swap));
        check("resp.no_memfill", 128'(no_memfill_o), 128'(exp_memfill));
        mem_ready_i = 1'($urandom_range(1));
        step();
        mem_ready_i = 1'b0;
        check_idle("after");
    endtask

    initial begin
        rst_ni            = 1'b0;
        l1_miss_valid_i   = 1'b0;
        l1_miss_addr_i    = '0;
        l1_victim_valid_i = 1'b0;
        l1_victim_dirty_i = 1'b0;
        l1_victim_addr_i  = '0;
        l1_victim_data_i  = '0;
        vc_res_valid_i    = 1'b0;
        vc_res_dirty_i    = 1'b0;
        vc_res_data_i     = '0;
        vc_miss_i         = 1'b0;
        mem_ready_i       = 1'b0;
        mem_data_i        = '0;
        #1;
        check_idle("reset");
        step();
        step();
        rst_ni = 1'b1;
        step();
        check_idle("post_reset");

        // VC hit with dirty valid victim.
        txn(32'h0000_1230, 1'b1, 1'b1, 32'h0000_4560, {16{8'hA5}}, 1'b1, 1'b0, {16{8'h11}},
            0, '0, 1'b0);
        // VC miss, four memory wait cycles.
        txn(32'h0000_2000, 1'b1, 1'b0, 32'h0000_7000, rand128(), 1'b0, 1'b0, '0, 4,
            {4{32'hDEAD_BEEF}}, 1'b0);
        // Invalid victim on VC miss.
        txn(32'h0000_3000, 1'b0, 1'b1, 32'h0000_8000, rand128(), 1'b0, 1'b0, '0, 2,
            rand128(), 1'b0);
        // Second miss pulse while waiting for memory.
        txn(32'h0000_4000, 1'b1, 1'b1, 32'h0000_9000, rand128(), 1'b0, 1'b0, '0, 3,
            rand128(), 1'b1);

        // Reset while in MEM_REQ.
        l1_miss_valid_i = 1'b1;
        l1_miss_addr_i  = 32'h0000_5000;
        step();
        l1_miss_valid_i = 1'b0;
        step();
        vc_res_valid_i = 1'b0;
        step();
        step();
        check("rst.pre_mem_req", 128'(mem_req_valid_o), 128'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        exp_swap    = '0;
        exp_memfill = '0;
        check_idle("rst.mid");
        mem_ready_i    = 1'b1;
        mem_data_i     = rand128();
        vc_res_valid_i = 1'b1;
        step();
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_idle("rst.after");
        end
        mem_ready_i    = 1'b0;
        vc_res_valid_i = 1'b0;

        // Counter wrap.
        force dut.no_swap_q = 32'hFFFF_FFFF;
        step();
        release dut.no_swap_q;
        exp_swap = 32'hFFFF_FFFF;
        check("wrap.preload", 128'(no_swap_o), 128'(exp_swap));
        txn($urandom(), 1'b1, 1'b0, $urandom(), rand128(), 1'b1, 1'b1, rand128(), 0, '0, 1'b0);
        check("wrap.no_swap", 128'(no_swap_o), 128'd0);

        for (int t = 0; t < 40; t++) begin
            txn($urandom(), 1'($urandom_range(1)), 1'($urandom_range(1)), $urandom(),
                rand128(), 1'($urandom_range(1)), 1'($urandom_range(1)), rand128(),
                int'($urandom_range(6, 1)), rand128(), 1'($urandom_range(1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
